// File: rtl/keypad_pkg.sv
// Shared types, keymap and row-pattern helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Indexed [row][col]; row r is the active-low bit r of the row returns.
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // True when exactly one row line is pulled low.
  function automatic logic onehot_low(input logic [3:0] v);
    logic [3:0] n;
    n = ~v;
    return (n != 4'b0000) && ((n & (n - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad-side and key-code-side signals of the scanner bundled as one port.
interface keypad_if;
  import keypad_pkg::*;

  logic       tick;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;

  modport master (
    input  tick,
    input  rows,
    output cols,
    output key,
    output key_valid
  );

  modport slave (
    output tick,
    output rows,
    input  cols,
    input  key,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer with a configurable reset value, one chain per bit.
module sync2 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk) begin
      if (reset) begin
        meta[gi] <= RESET_VAL[gi];
        q[gi]    <= RESET_VAL[gi];
      end else begin
        meta[gi] <= d[gi];
        q[gi]    <= meta[gi];
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce; one key_valid
// strobe per accepted press, stepped by the divider's one-cycle tick.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [3:0]       rows_s;
  state_t           state;
  logic [1:0]       col;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       pattern;
  logic [3:0]       key;
  logic             key_valid;

  sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rows),
    .q     (rows_s)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      cnt       <= '0;
      pattern   <= 4'b1111;
      key       <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (bus.tick) begin
        unique case (state)
          SCAN: begin
            if (onehot_low(rows_s)) begin
              pattern <= rows_s;
              cnt     <= '0;
              state   <= DEBOUNCE;
            end else begin
              col <= col + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (rows_s == pattern) begin
              cnt <= cnt_inc;
              if (cnt_inc == LAST) begin
                key       <= KEYMAP[row_index(pattern)][col];
                key_valid <= 1'b1;
                state     <= HELD;
              end
            end else begin
              // Glitch or pattern change: restart detection on the same column.
              state <= SCAN;
            end
          end
          HELD: begin
            if (rows_s == 4'b1111) begin
              cnt   <= '0;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (rows_s == 4'b1111) begin
              cnt <= cnt_inc;
              if (cnt_inc == LAST) begin
                col   <= col + 2'd1;
                state <= SCAN;
              end
            end else begin
              // A bounce during release counts as still held, so no re-strobe.
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    assign bus.cols[gi] = (col != 2'(gi));
  end

  assign bus.key       = key;
  assign bus.key_valid = key_valid;

endmodule
